// File: rtl/mpu6050_i2c_target_if.sv
// Open-drain I2C pad bundle between a bus initiator model and the MPU6050 target.
// sda_in carries the resolved wired-AND line level, sda_oe is the target's pull-down request.
`timescale 1ns/1ps
interface mpu6050_i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/mpu6050_i2c_target.sv
// MPU6050-compatible I2C target: config registers, WHO_AM_I and a coherent
// accelerometer snapshot, oversampling SCL/SDA on clk_in.
`timescale 1ns/1ps
module mpu6050_i2c_target #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic                       clk_in,
  input  logic                       n_rst,
  mpu6050_i2c_target_if.slave        bus,
  input  logic [47:0]                sample_in,
  input  logic                       sample_valid_in,
  output logic [7:0]                 pwr_mgmt_1,
  output logic [7:0]                 smplrt_div,
  output logic [7:0]                 config_reg,   // register CONFIG; "config" is a reserved word
  output logic [7:0]                 gyro_config,
  output logic [7:0]                 accel_config,
  output logic                       wr_strobe,
  output logic [7:0]                 wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t      state;
  logic        scl_meta, scl_sync, scl_prev;
  logic        sda_meta, sda_sync, sda_prev;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_shift;
  logic [7:0]  ptr;
  logic [7:0]  rd_byte;
  logic [3:0]  bit_cnt;
  logic        ack_phase;
  logic        rd_mode;
  logic        sda_drive;
  logic [47:0] live_data;
  logic [47:0] snap_data;

  assign bus.sda_oe = sda_drive;

  // Synchronizers reset to the idle-bus level so reset release never fakes a START.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      {scl_prev, scl_sync, scl_meta} <= 3'b111;
      {sda_prev, sda_sync, sda_meta} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      {scl_prev, scl_sync, scl_meta} <= {scl_sync, scl_meta, bus.scl_in};
      {sda_prev, sda_sync, sda_meta} <= {sda_sync, sda_meta, bus.sda_in};
    end
  end

  assign scl_rise  =  scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync &  scl_prev;
  assign start_det =  scl_sync &  scl_prev & ~sda_sync &  sda_prev;
  assign stop_det  =  scl_sync &  scl_prev &  sda_sync & ~sda_prev;
  assign rx_byte   = {rx_shift, sda_sync};

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) live_data <= '0;
    else if (sample_valid_in) live_data <= sample_in;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves rd_byte unassigned (no latch).
    rd_byte = 8'h00;
    case (ptr)
      8'h19:   rd_byte = smplrt_div;
      8'h1A:   rd_byte = config_reg;
      8'h1B:   rd_byte = gyro_config;
      8'h1C:   rd_byte = accel_config;
      8'h3B:   rd_byte = snap_data[47:40];
      8'h3C:   rd_byte = snap_data[39:32];
      8'h3D:   rd_byte = snap_data[31:24];
      8'h3E:   rd_byte = snap_data[23:16];
      8'h3F:   rd_byte = snap_data[15:8];
      8'h40:   rd_byte = snap_data[7:0];
      8'h6B:   rd_byte = pwr_mgmt_1;
      8'h75:   rd_byte = WHO_AM_I_VAL;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the register file is a handful of flops, so every byte gets a reset value.
      state        <= S_IDLE;
      sda_drive    <= 1'b0;
      busy         <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      bit_cnt      <= '0;
      ack_phase    <= 1'b0;
      rd_mode      <= 1'b0;
      ptr          <= 8'h00;
      snap_data    <= '0;
      pwr_mgmt_1   <= 8'h40;
      smplrt_div   <= 8'h00;
      config_reg   <= 8'h00;
      gyro_config  <= 8'h00;
      accel_config <= 8'h00;
      wr_strobe    <= 1'b0;
      wr_addr      <= 8'h00;
      wr_data      <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state     <= S_IDLE;
        sda_drive <= 1'b0;
        busy      <= 1'b0;
      end else if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        sda_drive <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state   <= S_ADDR_ACK;
                busy    <= 1'b1;
                rd_mode <= rx_byte[0];
                if (rx_byte[0]) snap_data <= live_data;
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
          end

          // First fall after the 8th bit asserts ACK; the next one ends it.
          S_ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_drive <= 1'b1;
              ack_phase <= 1'b1;
            end else if (rd_mode) begin
              state     <= S_RD_DATA;
              sda_drive <= ~rd_byte[7];
              tx_shift  <= {rd_byte[6:0], 1'b0};
              bit_cnt   <= 4'd1;
              ptr       <= ptr + 8'd1;
            end else begin
              state     <= S_PTR;
              sda_drive <= 1'b0;
              bit_cnt   <= '0;
            end
          end

          S_PTR: if (scl_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr       <= rx_byte;
              state     <= S_PTR_ACK;
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
            end
          end

          S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_drive <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_drive <= 1'b0;
              state     <= S_WR_DATA;
              bit_cnt   <= '0;
            end
          end

          S_WR_DATA: if (scl_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              case (ptr)
                8'h19:   smplrt_div   <= rx_byte;
                8'h1A:   config_reg   <= rx_byte;
                8'h1B:   gyro_config  <= rx_byte;
                8'h1C:   accel_config <= rx_byte;
                8'h6B:   pwr_mgmt_1   <= rx_byte;
                default: ;
              endcase
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
              wr_strobe <= 1'b1;
              ptr       <= ptr + 8'd1;
              state     <= S_WR_ACK;
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
            end
          end

          // bit_cnt counts bits already placed on SDA; the 8th fall hands the line back.
          S_RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_drive <= 1'b0;
              state     <= S_RD_ACK;
              ack_phase <= 1'b0;
            end else begin
              sda_drive <= ~tx_shift[7];
              tx_shift  <= {tx_shift[6:0], 1'b0};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end

          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_sync) state <= S_IGNORE;
              else ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              state     <= S_RD_DATA;
              sda_drive <= ~rd_byte[7];
              tx_shift  <= {rd_byte[6:0], 1'b0};
              bit_cnt   <= 4'd1;
              ptr       <= ptr + 8'd1;
            end
          end

          S_IDLE, S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// Bench for mpu6050_i2c_target: bit-banged I2C initiator plus a register-map model
// of the sensor, directed scenarios followed by randomized transactions.
`timescale 1ns/1ps
module tb_mpu6050_i2c_target;
  localparam int Q = 60;  // quarter SCL period: SCL = 240 ns against a 10 ns clk_in

  logic        clk_in = 1'b0;
  logic        n_rst  = 1'b0;
  logic        scl_m  = 1'b1;
  logic        sda_m  = 1'b1;
  logic [47:0] sample_in = '0;
  logic        sample_valid_in = 1'b0;
  logic [7:0]  pwr_mgmt_1, smplrt_div, config_reg, gyro_config, accel_config;
  logic        wr_strobe, busy;
  logic [7:0]  wr_addr, wr_data;

  always #5 clk_in = ~clk_in;

  mpu6050_i2c_target_if bus_if ();
  assign bus_if.scl_in = scl_m;
  assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

  mpu6050_i2c_target dut (
    .clk_in          (clk_in),
    .n_rst           (n_rst),
    .bus             (bus_if),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .pwr_mgmt_1      (pwr_mgmt_1),
    .smplrt_div      (smplrt_div),
    .config_reg      (config_reg),
    .gyro_config     (gyro_config),
    .accel_config    (accel_config),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the sensor as seen from the bus.
  logic [7:0]  m_pwr, m_smp, m_cfg, m_gyro, m_accel, m_ptr;
  logic [47:0] m_live, m_snap;
  logic [15:0] exp_q[$];
  logic [15:0] strobe_q[$];
  logic [7:0]  wbuf[16];
  logic [7:0]  rbuf[16];
  logic [7:0]  ebuf[16];
  bit          oe_seen;
  logic        oe_prev = 1'b0;

  always @(negedge clk_in) if (wr_strobe === 1'b1) strobe_q.push_back({wr_addr, wr_data});

  // The target may only move SDA while SCL is low.
  always @(negedge clk_in) begin
    if (bus_if.sda_oe !== oe_prev) begin
      checks++;
      if (scl_m) begin
        errors++;
        $display("FAIL sda_oe_while_scl_high: sda_oe went %b at %0t, required stable", bus_if.sda_oe, $time);
      end
    end
    oe_prev = bus_if.sda_oe;
    if (bus_if.sda_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic m_reset();
    m_pwr = 8'h40; m_smp = 8'h00; m_cfg = 8'h00; m_gyro = 8'h00; m_accel = 8'h00;
    m_ptr = 8'h00; m_live = '0; m_snap = '0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] p);
    int k;
    if (p >= 8'h3B && p <= 8'h40) begin
      k = int'(p) - 'h3B;
      return m_snap[47 - 8*k -: 8];
    end
    case (p)
      8'h19: return m_smp;
      8'h1A: return m_cfg;
      8'h1B: return m_gyro;
      8'h1C: return m_accel;
      8'h6B: return m_pwr;
      8'h75: return 8'h68;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write_seq(input logic [7:0] p, input int n);
    m_ptr = p;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({m_ptr, wbuf[i]});
      case (m_ptr)
        8'h19: m_smp   = wbuf[i];
        8'h1A: m_cfg   = wbuf[i];
        8'h1B: m_gyro  = wbuf[i];
        8'h1C: m_accel = wbuf[i];
        8'h6B: m_pwr   = wbuf[i];
        default: ;
      endcase
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic m_read_seq(input int n);
    m_snap = m_live;
    for (int i = 0; i < n; i++) begin
      ebuf[i] = m_read(m_ptr);
      m_ptr   = m_ptr + 8'd1;
    end
  endtask

  task automatic pulse_sample(input logic [47:0] v);
    @(negedge clk_in);
    sample_in = v;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    m_live = v;
  endtask

  // Bus primitives. Every primitive leaves SCL low except bus_stop.
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    ack = ~bus_if.sda_in;
    #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b, output logic oe_in_ack);
    sda_m = 1'b1;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1; #Q;
      b = {b[6:0], bus_if.sda_in};
      #Q; scl_m = 1'b0;
    end
    sda_m = nack; #Q; scl_m = 1'b1; #Q;
    oe_in_ack = bus_if.sda_oe;
    #Q; scl_m = 1'b0; sda_m = 1'b1; #Q;
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n,
                           input bit do_stop, output int nacks);
    logic ack;
    nacks = 0;
    bus_start();
    send_byte({a, 1'b0}, ack); if (!ack) nacks++;
    send_byte(p, ack);         if (!ack) nacks++;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack); if (!ack) nacks++;
    end
    if (do_stop) bus_stop();
  endtask

  task automatic read_txn(input logic [6:0] a, input int n, input bit do_stop,
                          output int nacks, output int oe_err);
    logic ack, oe;
    nacks = 0;
    oe_err = 0;
    bus_start();
    send_byte({a, 1'b1}, ack); if (!ack) nacks++;
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, rbuf[i], oe);
      if (oe !== 1'b0) oe_err++;
    end
    if (do_stop) bus_stop();
  endtask

  task automatic test_reset();
    logic [7:0] got[10];
    logic [7:0] req[10];
    got = '{8'(bus_if.sda_oe), pwr_mgmt_1, smplrt_div, config_reg, gyro_config,
            accel_config, 8'(wr_strobe), wr_addr, wr_data, 8'(busy)};
    req = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== req[i]) begin
        errors++;
        $display("FAIL reset_value[%0d]: got %h required %h", i, got[i], req[i]);
      end
    end
  endtask

  task automatic test_wake();
    int nacks;
    strobe_q.delete(); exp_q.delete();
    wbuf[0] = 8'h00;
    write_txn(7'h68, 8'h6B, 1, 1'b1, nacks);
    m_write_seq(8'h6B, 1);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL wake_acks: %0d nacks, required 0", nacks); end
    checks++; if (pwr_mgmt_1 !== 8'h00) begin errors++; $display("FAIL wake_pwr: got %h required 00", pwr_mgmt_1); end
    checks++; if (strobe_q.size() !== 1) begin errors++; $display("FAIL wake_strobes: got %0d required 1", strobe_q.size()); end
    else begin
      checks++;
      if (strobe_q[0] !== 16'h6B00) begin errors++; $display("FAIL wake_wr: got %h required 6b00", strobe_q[0]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wake_busy_after_stop: got %b required 0", busy); end
  endtask

  task automatic test_autoinc();
    int nacks;
    strobe_q.delete(); exp_q.delete();
    wbuf[0] = 8'h07; wbuf[1] = 8'h03;
    write_txn(7'h68, 8'h19, 2, 1'b1, nacks);
    m_write_seq(8'h19, 2);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL autoinc_acks: %0d nacks, required 0", nacks); end
    checks++; if (smplrt_div !== 8'h07) begin errors++; $display("FAIL autoinc_smplrt: got %h required 07", smplrt_div); end
    checks++; if (config_reg !== 8'h03) begin errors++; $display("FAIL autoinc_config: got %h required 03", config_reg); end
    checks++;
    if (strobe_q.size() !== 2 || strobe_q[0] !== 16'h1907 || strobe_q[1] !== 16'h1A03) begin
      errors++;
      $display("FAIL autoinc_strobes: got %0d pulses, required 2 (1907,1a03)", strobe_q.size());
    end
  endtask

  task automatic test_whoami();
    int nacks, nacks_r, oe_err;
    write_txn(7'h68, 8'h75, 0, 1'b0, nacks);
    m_ptr = 8'h75;
    read_txn(7'h68, 1, 1'b0, nacks_r, oe_err);
    m_read_seq(1);
    checks++; if (nacks + nacks_r !== 0) begin errors++; $display("FAIL whoami_acks: %0d nacks, required 0", nacks + nacks_r); end
    checks++; if (rbuf[0] !== 8'h68) begin errors++; $display("FAIL whoami_value: got %h required 68", rbuf[0]); end
    checks++; if (bus_if.sda_oe !== 1'b0) begin errors++; $display("FAIL whoami_release: sda_oe %b required 0", bus_if.sda_oe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL whoami_busy_before_stop: got %b required 1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL whoami_busy_after_stop: got %b required 0", busy); end
  endtask

  task automatic test_snapshot();
    int nacks;
    logic ack, oe;
    logic [7:0] b;
    pulse_sample(48'h010203040506);
    write_txn(7'h68, 8'h3B, 0, 1'b0, nacks);
    m_ptr = 8'h3B;
    m_read_seq(6);
    bus_start();
    send_byte({7'h68, 1'b1}, ack);
    for (int i = 0; i < 6; i++) begin
      recv_byte(i == 5, b, oe);
      checks++;
      if (b !== 8'(i + 1) || b !== ebuf[i]) begin
        errors++;
        $display("FAIL snapshot_byte[%0d]: got %h required %h", i, b, 8'(i + 1));
      end
      if (i == 1) pulse_sample(48'hAAAAAAAAAAAA);
    end
    bus_stop();
    write_txn(7'h68, 8'h3B, 0, 1'b0, nacks);
    m_ptr = 8'h3B;
    read_txn(7'h68, 1, 1'b1, nacks, oe);
    m_read_seq(1);
    checks++; if (rbuf[0] !== 8'hAA) begin errors++; $display("FAIL snapshot_refresh: got %h required aa", rbuf[0]); end
  endtask

  task automatic test_nomatch();
    int nacks;
    strobe_q.delete();
    oe_seen = 1'b0;
    wbuf[0] = 8'h55; wbuf[1] = 8'h66;
    write_txn(7'h69, 8'h1A, 2, 1'b1, nacks);
    checks++; if (nacks !== 4) begin errors++; $display("FAIL nomatch_nacks: got %0d required 4", nacks); end
    checks++; if (oe_seen) begin errors++; $display("FAIL nomatch_sda_oe: driven 1, required 0 throughout"); end
    checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL nomatch_strobes: got %0d required 0", strobe_q.size()); end
    checks++;
    if ({pwr_mgmt_1, smplrt_div, config_reg, gyro_config, accel_config} !== {m_pwr, m_smp, m_cfg, m_gyro, m_accel}) begin
      errors++;
      $display("FAIL nomatch_regs: got %h required %h", {pwr_mgmt_1, smplrt_div, config_reg, gyro_config, accel_config},
               {m_pwr, m_smp, m_cfg, m_gyro, m_accel});
    end
  endtask

  task automatic test_midbyte_restart();
    int nacks;
    logic ack;
    strobe_q.delete(); exp_q.delete();
    bus_start();
    send_byte({7'h68, 1'b0}, ack);
    send_byte(8'h1C, ack);
    send_bits(8'hFF, 3);
    wbuf[0] = 8'h5A;
    write_txn(7'h68, 8'h1B, 1, 1'b1, nacks);
    m_write_seq(8'h1B, 1);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL restart_acks: %0d nacks, required 0", nacks); end
    checks++; if (accel_config !== m_accel) begin errors++; $display("FAIL restart_partial: accel_config %h required %h", accel_config, m_accel); end
    checks++; if (gyro_config !== 8'h5A) begin errors++; $display("FAIL restart_write: gyro_config %h required 5a", gyro_config); end
    checks++;
    if (strobe_q.size() !== 1 || strobe_q[0] !== 16'h1B5A) begin
      errors++;
      $display("FAIL restart_strobes: got %0d pulses, required 1 (1b5a)", strobe_q.size());
    end
  endtask

  task automatic test_wrap();
    int nacks, oe_err;
    strobe_q.delete(); exp_q.delete();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(7'h68, 8'hFF, 2, 1'b1, nacks);
    m_write_seq(8'hFF, 2);
    checks++;
    if (strobe_q.size() !== 2 || strobe_q[0] !== 16'hFF11 || strobe_q[1] !== 16'h0022) begin
      errors++;
      $display("FAIL wrap_strobes: got %0d pulses, required 2 (ff11,0022)", strobe_q.size());
    end
    read_txn(7'h68, 1, 1'b1, nacks, oe_err);
    m_read_seq(1);
    checks++; if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL wrap_read_0x01: got %h required %h", rbuf[0], ebuf[0]); end
  endtask

  task automatic test_random();
    logic [7:0] ptr_tab[9] = '{8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h3B, 8'h3D, 8'h40, 8'h6B, 8'h75};
    logic [7:0] p;
    logic [47:0] v;
    int n, nacks, nacks_r, oe_err;
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = {$urandom(), 16'($urandom())};
        pulse_sample(v);
      end
      p = ($urandom_range(0, 4) == 0) ? 8'($urandom()) : ptr_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom());
        strobe_q.delete(); exp_q.delete();
        write_txn(7'h68, p, n, 1'b1, nacks);
        m_write_seq(p, n);
        checks++; if (nacks !== 0) begin errors++; $display("FAIL rand_wr_acks[%0d]: %0d nacks, required 0", t, nacks); end
        checks++;
        if (strobe_q.size() !== exp_q.size()) begin
          errors++;
          $display("FAIL rand_wr_strobes[%0d]: got %0d pulses required %0d", t, strobe_q.size(), exp_q.size());
        end else begin
          for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (strobe_q[i] !== exp_q[i]) begin
              errors++;
              $display("FAIL rand_wr_event[%0d.%0d]: got %h required %h", t, i, strobe_q[i], exp_q[i]);
            end
          end
        end
        checks++;
        if ({pwr_mgmt_1, smplrt_div, config_reg, gyro_config, accel_config} !== {m_pwr, m_smp, m_cfg, m_gyro, m_accel}) begin
          errors++;
          $display("FAIL rand_wr_regs[%0d]: got %h required %h", t,
                   {pwr_mgmt_1, smplrt_div, config_reg, gyro_config, accel_config}, {m_pwr, m_smp, m_cfg, m_gyro, m_accel});
        end
      end else begin
        n = $urandom_range(1, 6);
        nacks = 0;
        if ($urandom_range(0, 1) == 0) begin
          write_txn(7'h68, p, 0, 1'b0, nacks);
          m_ptr = p;
        end
        read_txn(7'h68, n, 1'b1, nacks_r, oe_err);
        m_read_seq(n);
        checks++;
        if (nacks + nacks_r !== 0 || oe_err !== 0) begin
          errors++;
          $display("FAIL rand_rd_protocol[%0d]: nacks %0d ack-slot drives %0d, required 0/0", t, nacks + nacks_r, oe_err);
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rbuf[i] !== ebuf[i]) begin
            errors++;
            $display("FAIL rand_rd_byte[%0d.%0d]: got %h required %h", t, i, rbuf[i], ebuf[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midread();
    int nacks;
    logic ack;
    wbuf[0] = 8'h01;
    write_txn(7'h68, 8'h6B, 1, 1'b1, nacks);
    write_txn(7'h68, 8'h75, 0, 1'b1, nacks);
    bus_start();
    send_byte({7'h68, 1'b1}, ack);
    checks++; if (bus_if.sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving: sda_oe %b required 1", bus_if.sda_oe); end
    #3 n_rst = 1'b0;
    #1;
    checks++; if (bus_if.sda_oe !== 1'b0) begin errors++; $display("FAIL midread_reset_sda_oe: got %b required 0", bus_if.sda_oe); end
    checks++; if (pwr_mgmt_1 !== 8'h40) begin errors++; $display("FAIL midread_reset_pwr: got %h required 40", pwr_mgmt_1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_reset_busy: got %b required 0", busy); end
    #26 n_rst = 1'b1;
    m_reset();
    #(2*Q);
    wbuf[0] = 8'h05;
    strobe_q.delete();
    write_txn(7'h68, 8'h6B, 1, 1'b1, nacks);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL post_reset_acks: %0d nacks, required 0", nacks); end
    checks++; if (pwr_mgmt_1 !== 8'h05) begin errors++; $display("FAIL post_reset_pwr: got %h required 05", pwr_mgmt_1); end
  endtask

  initial begin
    m_reset();
    #20;
    test_reset();
    #20 n_rst = 1'b1;
    #(4*Q);
    test_wake();
    test_autoinc();
    test_whoami();
    test_snapshot();
    test_nomatch();
    test_midbyte_restart();
    test_wrap();
    test_random();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
